axi_slice_array: RTL

- Parametrised array of independent valid/ready register slices, one per handshake channel.
- Inserted between the core's AXI master and the flattened top-level AXI pins to break timing paths.
- Each channel is bypass, forward-registered, or fully registered (2-entry skid), selected per channel.
- Adds per-channel occupancy and saturating stall counters as debug outputs.

---
 rtl/holy_slice_pkg.sv | 10 +
 rtl/slice_channel.sv | 91 +++++++++
 rtl/axi_slice_array.sv | 44 ++++
 3 files changed

// File: rtl/holy_slice_pkg.sv
// holy_slice_pkg: shared types and defaults for the valid/ready slice array
package holy_slice_pkg;
    typedef enum logic [1:0] {
        SLICE_BYPASS = 2'd0,
        SLICE_FWD    = 2'd1,
        SLICE_FULL   = 2'd2
    } slice_mode_t;
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} slice_state_t;
    localparam int STALL_W_DEF = 16;
endpackage

// File: rtl/slice_channel.sv
// slice_channel: one valid/ready register slice with its saturating stall counter
module slice_channel
    import holy_slice_pkg::*;
#(
    parameter int         W       = 64,
    parameter logic [1:0] MODE    = SLICE_FULL,
    parameter int         STALL_W = STALL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [W-1:0]       s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [W-1:0]       m_data,
    input  logic               clear_stats,
    output logic [1:0]         occ,
    output logic [STALL_W-1:0] stall
);
    localparam logic [STALL_W-1:0] SAT = '1;
    logic [STALL_W-1:0] cnt;
    if (MODE == SLICE_BYPASS) begin : g_byp
        assign m_valid = s_valid;
        assign m_data  = s_data;
        assign s_ready = m_ready;
        assign occ     = 2'd0;
    end else if (MODE == SLICE_FWD) begin : g_fwd
        logic         v;
        logic [W-1:0] d;
        // output register: s_ready means empty or draining, so valid simply follows s_valid
        always_ff @(posedge clk) begin
            if (rst) begin
                v <= 1'b0;
                d <= '0;
            end else if (s_ready) begin
                v <= s_valid;
                if (s_valid) d <= s_data;
            end
        end
        assign s_ready = rst | !v | m_ready;
        assign m_valid = v & !rst;
        assign m_data  = rst ? '0 : d;
        assign occ     = {1'b0, m_valid};
    end else begin : g_full
        slice_state_t st, nxt;
        logic [W-1:0] main_q, skid_q;
        logic         rdy_q, push, pop;
        assign push = s_valid & s_ready;
        assign pop  = (st != S_EMPTY) & m_ready;
        // state and registered s_ready, both computed from next state so no path crosses
        always_ff @(posedge clk) begin
            if (rst) begin
                st    <= S_EMPTY;
                rdy_q <= 1'b0;
            end else begin
                st    <= nxt;
                rdy_q <= nxt != S_TWO;
            end
        end
        // occupancy transitions of the 2-entry skid buffer
        always_comb begin
            nxt = st;
            if (st == S_EMPTY && push) nxt = S_ONE;
            else if (st == S_ONE && push && !pop) nxt = S_TWO;
            else if (st == S_ONE && pop && !push) nxt = S_EMPTY;
            else if (st == S_TWO && pop) nxt = S_ONE;
        end
        // main feeds the output; skid catches the beat that arrives while main is stalled
        always_ff @(posedge clk) begin
            if (rst) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                if ((st == S_EMPTY && push) || (st == S_ONE && push && pop)) main_q <= s_data;
                if (st == S_ONE && push && !pop) skid_q <= s_data;
                if (st == S_TWO && pop) main_q <= skid_q;
            end
        end
        assign s_ready = rdy_q & !rst;
        assign m_valid = (st != S_EMPTY) & !rst;
        assign m_data  = rst ? '0 : main_q;
        assign occ     = rst ? 2'd0 : st == S_TWO ? 2'd2 : st == S_ONE ? 2'd1 : 2'd0;
    end
    // stall counter saturates instead of wrapping; clear has priority over a stall
    always_ff @(posedge clk) begin
        if (rst || clear_stats) cnt <= '0;
        else if (m_valid && !m_ready && cnt != SAT) cnt <= cnt + STALL_W'(1);
    end
    assign stall = rst ? '0 : cnt;
endmodule

// File: rtl/axi_slice_array.sv
// axi_slice_array: per-channel register slices between the core AXI master and the pins
module axi_slice_array
    import holy_slice_pkg::*;
#(
    parameter int                  NUM_CH  = 5,
    parameter int                  W       = 64,
    parameter logic [2*NUM_CH-1:0] MODE    = {NUM_CH{2'd2}},
    parameter int                  STALL_W = STALL_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         s_valid,
    output logic [NUM_CH-1:0]         s_ready,
    input  logic [NUM_CH*W-1:0]       s_data,
    output logic [NUM_CH-1:0]         m_valid,
    input  logic [NUM_CH-1:0]         m_ready,
    output logic [NUM_CH*W-1:0]       m_data,
    input  logic                      clear_stats,
    output logic [2*NUM_CH-1:0]       dbg_occ,
    output logic [STALL_W*NUM_CH-1:0] dbg_stall
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (MODE[2*i+:2] == 2'd3) begin : g_bad
            $error("axi_slice_array: channel %0d has illegal MODE 3", i);
        end
        slice_channel #(
            .W       (W),
            .MODE    (MODE[2*i+:2]),
            .STALL_W (STALL_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .s_valid     (s_valid[i]),
            .s_ready     (s_ready[i]),
            .s_data      (s_data[i*W+:W]),
            .m_valid     (m_valid[i]),
            .m_ready     (m_ready[i]),
            .m_data      (m_data[i*W+:W]),
            .clear_stats (clear_stats),
            .occ         (dbg_occ[2*i+:2]),
            .stall       (dbg_stall[i*STALL_W+:STALL_W])
        );
    end
endmodule
